// File: rtl/dispatch_batch_sequencer_if.sv
// Handshake bundle: per-slot dispatch requests in, lane-sized batches out to the execution unit.
interface dispatch_batch_sequencer_if #(
  parameter int NUM_REQS    = 4,
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int DATAW       = 32,
  parameter int HDRW        = 64
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int REQ_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  logic [NUM_REQS-1:0]                             in_valid;
  logic [NUM_REQS-1:0][HDRW-1:0]                   in_hdr;
  logic [NUM_REQS-1:0][NUM_THREADS-1:0]            in_tmask;
  logic [NUM_REQS-1:0][NUM_THREADS-1:0][DATAW-1:0] in_data;
  logic [NUM_REQS-1:0]                             in_ready;

  logic                            out_valid;
  logic                            out_ready;
  logic [HDRW-1:0]                 out_hdr;
  logic [NUM_LANES-1:0]            out_tmask;
  logic [NUM_LANES-1:0][DATAW-1:0] out_data;
  logic [PID_W-1:0]                out_pid;
  logic                            out_sop;
  logic                            out_eop;
  logic [REQ_W-1:0]                out_req;

  modport slave (
    input  in_valid, in_hdr, in_tmask, in_data, out_ready,
    output in_ready, out_valid, out_hdr, out_tmask, out_data, out_pid,
           out_sop, out_eop, out_req
  );

  modport master (
    output in_valid, in_hdr, in_tmask, in_data, out_ready,
    input  in_ready, out_valid, out_hdr, out_tmask, out_data, out_pid,
           out_sop, out_eop, out_req
  );
endinterface

// File: rtl/dispatch_batch_sequencer.sv
// Round-robin picks an issue slot, locks onto it and streams its nonempty lane batches to one
// execution unit; the request is popped when its last batch is accepted.
module dispatch_batch_sequencer #(
  parameter int NUM_REQS      = 4,
  parameter int NUM_THREADS   = 4,
  parameter int NUM_LANES     = 2,
  parameter int DATAW         = 32,
  parameter int HDRW          = 64,
  parameter int PERF_CTR_BITS = 44
) (
  input  logic                       clk,
  input  logic                       reset,
  dispatch_batch_sequencer_if.slave  bus,
  output logic [PERF_CTR_BITS-1:0]   perf_stalls
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_W       = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1;
  localparam int REQ_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  if ((NUM_THREADS % NUM_LANES) != 0) begin : g_bad_lanes
    $error("NUM_THREADS must be a multiple of NUM_LANES");
  end

  typedef enum logic {S_ARB, S_LOCKED} state_t;

  state_t                   r_state, w_state_nxt;
  logic [REQ_W-1:0]         r_lock_idx, w_lock_idx_nxt;
  logic [REQ_W-1:0]         r_rr_ptr, w_rr_ptr_nxt;
  logic [PID_W-1:0]         r_pid, w_pid_nxt;
  logic [PERF_CTR_BITS-1:0] r_perf, w_perf_nxt;

  logic [REQ_W-1:0]                  w_sel, w_idx;
  logic                              w_scan_found, w_cur_found;
  logic [NUM_THREADS-1:0]            w_tmask;
  logic [NUM_THREADS-1:0][DATAW-1:0] w_data;
  logic [HDRW-1:0]                   w_hdr;
  logic [NUM_PACKETS-1:0]            w_bmask;
  logic [PID_W-1:0]                  w_cur, w_next;
  logic                              w_eop, w_valid, w_fire, w_stall;

  // Slot selection, batch masks and current/next batch.
  always_comb begin
    w_sel        = r_lock_idx;
    w_idx        = '0;
    w_scan_found = 1'b0;
    if (r_state == S_ARB) begin
      w_sel = r_rr_ptr;
      for (int unsigned i = 0; i < NUM_REQS; i++) begin
        w_idx = REQ_W'((32'(r_rr_ptr) + i) % 32'(NUM_REQS));
        if (!w_scan_found && bus.in_valid[w_idx]) begin
          w_sel        = w_idx;
          w_scan_found = 1'b1;
        end
      end
    end

    w_tmask = bus.in_tmask[w_sel];
    w_data  = bus.in_data[w_sel];
    w_hdr   = bus.in_hdr[w_sel];
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      w_bmask[p] = |w_tmask[p*NUM_LANES +: NUM_LANES];
    end

    // An all-zero mask leaves w_cur at 0 with an empty slice, giving the single-beat case.
    w_cur       = r_pid;
    w_cur_found = 1'b0;
    if (r_state == S_ARB) begin
      w_cur = '0;
      for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
        if (!w_cur_found && w_bmask[p]) begin
          w_cur       = PID_W'(p);
          w_cur_found = 1'b1;
        end
      end
    end

    w_eop  = 1'b1;
    w_next = w_cur;
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      if (w_eop && (p > 32'(w_cur)) && w_bmask[p]) begin
        w_next = PID_W'(p);
        w_eop  = 1'b0;
      end
    end
  end

  // Outputs and next state.
  always_comb begin
    w_valid = ~reset & ((r_state == S_LOCKED) | (|bus.in_valid));
    w_fire  = w_valid & bus.out_ready;
    w_stall = w_valid & ~bus.out_ready;

    bus.out_valid = w_valid;
    bus.out_hdr   = w_hdr;
    bus.out_tmask = w_tmask[32'(w_cur)*NUM_LANES +: NUM_LANES];
    bus.out_data  = w_data[32'(w_cur)*NUM_LANES +: NUM_LANES];
    bus.out_pid   = w_cur;
    bus.out_sop   = (r_state == S_ARB);
    bus.out_eop   = w_eop;
    bus.out_req   = w_sel;
    bus.in_ready  = '0;
    if (w_fire && w_eop) begin
      bus.in_ready[w_sel] = 1'b1;
    end

    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_pid_nxt      = r_pid;
    w_perf_nxt     = r_perf + PERF_CTR_BITS'(w_stall);
    if (w_fire) begin
      if (w_eop) begin
        w_state_nxt  = S_ARB;
        w_rr_ptr_nxt = (w_sel == REQ_W'(NUM_REQS - 1)) ? '0 : w_sel + 1'b1;
        w_pid_nxt    = '0;
      end else begin
        w_state_nxt    = S_LOCKED;
        w_lock_idx_nxt = w_sel;
        w_pid_nxt      = w_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_ARB;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_pid      <= '0;
      r_perf     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_pid      <= w_pid_nxt;
      r_perf     <= w_perf_nxt;
    end
  end

  assign perf_stalls = r_perf;
endmodule

// File: doc/dispatch_batch_sequencer.md
# dispatch_batch_sequencer

Sequences dispatched instructions from all issue slots onto one execution unit that is narrower than the warp. It sits between the per-issue-slot dispatch buffers and a shared execution unit with `NUM_LANES` lanes. Each cycle it round-robin arbitrates among the issue slots and locks onto the winner. It then streams that request's `NUM_THREADS` operands as `NUM_THREADS/NUM_LANES` lane batches, skipping batches whose thread mask is all zero, and pops the request when its last batch is accepted.

## Interface
- `NUM_REQS`, default 4: number of issue slots (requesters).
- `NUM_THREADS`, default 4: threads per request.
- `NUM_LANES`, default 2: execution lanes. `NUM_THREADS % NUM_LANES == 0` is required (elaboration assertion).
- `DATAW`, default 32: per-thread operand width.
- `HDRW`, default 64: per-request header width (uuid, wis, op, rd, PC, ...). Passed through opaquely.
- `PERF_CTR_BITS`, default 44: stall counter width.
- Derived: `NUM_PACKETS = NUM_THREADS/NUM_LANES`, `PID_W = max(1, clog2(NUM_PACKETS))`, `REQ_W = max(1, clog2(NUM_REQS))`.

Ports:
- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  NUM_REQS  request valid, one bit per issue slot.
- `in_hdr`  in  NUM_REQS×HDRW  request header.
- `in_tmask`  in  NUM_REQS×NUM_THREADS  thread mask.
- `in_data`  in  NUM_REQS×NUM_THREADS×DATAW  operands.
- `in_ready`  out  NUM_REQS  request pop.
- `out_valid`  out  1  batch valid.
- `out_ready`  in  1  execution unit accepts the batch.
- `out_hdr`  out  HDRW  header of the selected request.
- `out_tmask`  out  NUM_LANES  mask slice of the current batch.
- `out_data`  out  NUM_LANES×DATAW  operand slice of the current batch.
- `out_pid`  out  PID_W  batch index.
- `out_sop`  out  1  first emitted batch of the request.
- `out_eop`  out  1  last emitted batch of the request.
- `out_req`  out  REQ_W  source issue slot.
- `perf_stalls`  out  PERF_CTR_BITS  count of backpressure cycles.

## Operation
- State:
  - `locked` (1b).
  - `lock_idx` (REQ_W).
  - `rr_ptr` (REQ_W).
  - `pid_r` (PID_W).
- Selection:
  - When `locked=0`, `sel` is the first valid requester scanning from `rr_ptr` upward, with wrap-around.
  - When `locked=1`, `sel = lock_idx`.
- Batch masks: `bmask[p] = |in_tmask[sel][p*NUM_LANES +: NUM_LANES]`.
- Current batch:
  - When unlocked, the current batch is the first p with `bmask[p]`.
  - When locked, the current batch is `pid_r`.
  - If the whole tmask is zero, the request is emitted as a single batch with `pid=0`, `sop=eop=1`, `out_tmask=0`.
- `out_eop=1` when no p greater than the current batch has `bmask[p]=1`. `out_sop=1` when `locked=0`.
- `out_valid = ~reset & (locked | |in_valid)`.
- `out_hdr`, `out_tmask` and `out_data` are the `sel` request's header and current slice.
- On `out_valid & out_ready`:
  - Not eop: `locked←1`, `lock_idx←sel`, `pid_r←`next p with `bmask[p]`.
  - Eop: `in_ready[sel]=1` in the same cycle, `locked←0`, `rr_ptr←sel+1` (mod NUM_REQS), `pid_r←0`.
- `in_ready` is 0 for every other requester and in every other cycle.
- While locked, the selected request's `in_valid`, `in_hdr`, `in_tmask` and `in_data` must stay stable (upstream buffers guarantee this). New valids on other slots do not preempt the locked request.
- `perf_stalls` increments by 1 on each `out_valid & ~out_ready` cycle and wraps at 2^PERF_CTR_BITS.
- Reset:
  - `locked=0`, `rr_ptr=0`, `pid_r=0`, `perf_stalls=0`.
  - `out_valid=0` and `in_ready=0` while `reset` is high.
  - A reset mid-request abandons it with no `in_ready` pulse. After reset the request is re-sent from its first batch.
- With `NUM_PACKETS==1`, every beat is `sop=eop=1` and the block reduces to a round-robin arbiter.

## Timing
- Zero-latency path: out_* and `in_ready` are combinational from in_* and `out_ready`; there is no internal data storage.
- One batch per cycle under no backpressure. A request with k nonempty batches occupies exactly k accepted cycles.
- Back-to-back requests have no bubble: the cycle after an eop accept, arbitration picks the next requester.
- The `rr_ptr` update is visible the cycle after the eop accept.
- `out_*` hold stable while `out_valid & ~out_ready` (stable inputs, registered state unchanged).

## Test plan
- Full mask (NUM_THREADS=4, NUM_LANES=2), req0 with tmask 1111, data {d3,d2,d1,d0}, `out_ready=1`:
  - Cycle 0: pid0, data {d1,d0}, sop=1, eop=0.
  - Cycle 1: pid1, data {d3,d2}, eop=1, `in_ready[0]=1`.
- Skipped batch: tmask 1100 → a single beat with pid=1, sop=eop=1, out_tmask=11. tmask 0000 → a single beat with pid=0, out_tmask=00, then pop.
- Backpressure: tmask 1111 with `out_ready=0` for 3 cycles at pid1 → outputs held, no pop, `perf_stalls=3`, then eop accepted on release.
- Fairness: all 4 slots valid continuously, each tmask 1111 → grant order 0,1,2,3,0, each for 2 beats, with no interleaving inside a request.
- Lock: req2 locked at pid1 while req0 becomes valid → the next beat is still req2 pid1, then req0.
- Reset mid-request: reset asserted after pid0 is accepted → `out_valid=0`, no `in_ready` pulse. After release the request restarts at pid0 with sop=1 and rr_ptr=0.
